em_pipe_reg: RTL and testbench
==============================

# em_pipe_reg

Pipeline register between Execute (E) and Memory (M) in the P7 MIPS core. It captures the E-stage result, choosing between the ALU output and the HI/LO unit read-out. It also merges E-stage exception detection into the in-flight exception code and ages the hazard time-to-new (Tnew) counter. It flushes on exception/interrupt request (`req`) and inserts bubbles on `flush`.

## Interface
- `RESET_PC`, 32'h0000_3000: PC value loaded on `rst`.
- `HANDLER_PC`, 32'h0000_4180: PC value loaded on `req`.
- `clk` input 1: clock.
- `rst` input 1: reset; synchronous, active-high.
- `req` input 1: exception/interrupt taken this cycle; clear the stage.
- `flush` input 1: insert a bubble that keeps PC and BD.
- `e_pc` input 32: PC of the E instruction.
- `e_instr` input 32: instruction word.
- `e_alu_out` input 32: ALU result.
- `e_hilo_out` input 32: HI/LO read-out (mfhi/mflo).
- `e_hilo_sel` input 1: 1 selects `e_hilo_out` as the result.
- `e_rt_data` input 32: forwarded rt value (store data).
- `e_wa` input 5: destination GPR.
- `e_tnew` input 2: cycles until the result is ready, as seen at E.
- `e_bd` input 1: instruction is in a delay slot.
- `e_exc` input 5: ExcCode carried from F/D (0 = none).
- `e_ov` input 1: arithmetic overflow (add/addi/sub).
- `e_addr_ov` input 1: effective-address computation overflowed.
- `e_load`, `e_store` input 1 each: memory-access class.
- `m_pc`, `m_instr`, `m_result`, `m_rt_data` output 32 each: registered values.
- `m_wa` output 5.
- `m_tnew` output 2.
- `m_bd` output 1.
- `m_exc` output 5.
- `m_load`, `m_store` output 1 each.
- `m_valid` output 1: 0 for a bubble or cleared slot.

## Operation
- Update priority each `clk` edge: `rst` > `req` > `flush` > normal capture. There is no hold/stall input; the stage always advances.
- Normal capture:
  - All `m_*` take the corresponding `e_*` value.
  - `m_result` = `e_hilo_sel` ? `e_hilo_out` : `e_alu_out`.
  - `m_valid` = 1.
- Tnew aging: `m_tnew` = (`e_tnew` == 0) ? 0 : `e_tnew` − 1. The value saturates at 0 and never wraps to 3.
- Exception merge, first match wins:
  - `e_exc` ≠ 0 → keep `e_exc`.
  - `e_load` & `e_addr_ov` → AdEL (4).
  - `e_store` & `e_addr_ov` → AdES (5).
  - `e_ov` & !`e_load` & !`e_store` → Ov (12).
  - Otherwise 0.
- When `m_exc` ≠ 0, `m_wa` is forced to 0. This suppresses the writeback, and downstream Tnew forwarding uses that 0.
- `flush`:
  - `m_pc` and `m_bd` are captured from E as normal, so the cause/EPC logic sees the correct macro-PC.
  - `m_instr`, `m_result`, `m_rt_data`, `m_wa`, `m_tnew`, `m_exc`, `m_load`, `m_store` and `m_valid` all become 0.
- `req`: every output is set to 0, except `m_pc` = `HANDLER_PC`.
- `rst`: every output is set to 0, except `m_pc` = `RESET_PC`.
- `req` together with `flush`: the `req` result applies.

## Timing
- One-cycle latency: E values at edge N appear on `m_*` after edge N.
- All outputs are registered; there is no combinational path from input to output.
- `req` asserted mid-sequence discards the E instruction on that edge. The next edge captures normally.
- Consecutive `flush` cycles produce consecutive bubbles, each carrying the current `e_pc`.

## Configuration
- `EM_EXC_EN` defined:
  - Exception merge, the `m_exc`/`m_wa` suppression and `m_bd` are implemented as above.
- `EM_EXC_EN` undefined:
  - `m_exc` and `m_bd` are constant 0.
  - `e_exc`, `e_ov`, `e_addr_ov` and `e_bd` are ignored.
  - `m_wa` is always captured unmodified.
  - Intended for the P5/P6-compatible build without CP0.

## Structure
- Shared defines file: ExcCode constants (`EXC_NONE` 0, `EXC_ADEL` 4, `EXC_ADES` 5, `EXC_OV` 12), the Tnew width, `RESET_PC` and `HANDLER_PC` values.
- One natural sub-module: `exc_merge`, the combinational priority encoder producing the merged ExcCode. Instantiate it only under `EM_EXC_EN`.

## Test plan
- Reset: `rst`=1 for one edge → `m_pc`=0x3000; all other outputs 0; `m_valid`=0.
- Normal capture:
  - Stimulus: `e_pc`=0x3010, `e_alu_out`=0x55, `e_hilo_out`=0xAA, `e_hilo_sel`=1, `e_tnew`=2, `e_wa`=8.
  - Response: `m_result`=0xAA, `m_tnew`=1, `m_wa`=8, `m_valid`=1.
  - Repeat with `e_tnew`=0 → `m_tnew`=0.
- Exception priority:
  - `e_exc`=10 with `e_ov`=1 → `m_exc`=10, `m_wa`=0.
  - `e_load`=1, `e_addr_ov`=1 → `m_exc`=4.
  - `e_store`=1, `e_addr_ov`=1 → `m_exc`=5.
  - `e_ov`=1 alone → `m_exc`=12.
- Flush: `flush`=1, `e_pc`=0x3020, `e_bd`=1 → `m_pc`=0x3020, `m_bd`=1; `m_instr`, `m_wa`, `m_exc` and `m_valid` all 0.
- `req` priority: `req`=1 and `flush`=1 with valid E data → `m_pc`=0x4180, all other outputs 0. The next edge with `req`=0 captures E normally.
- Macro off: build without `EM_EXC_EN`, drive `e_ov`=1 and `e_wa`=9 → `m_exc`=0, `m_wa`=9.

Source files
------------

// File: rtl/em_pipe_reg_pkg.sv
// Shared definitions for the E/M pipeline register of the P7 MIPS core:
// ExcCode values, Tnew width, reset/handler PCs, the registered stage bundle
// and small helpers used to build next-state values.
// Optional feature macro: EM_EXC_EN (exception merge, ExcCode/BD tracking).
package em_pipe_reg_pkg;

    localparam int TNEW_W = 2;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    // Everything the M stage sees, held in one packed register so that
    // reset/clear can be written as a single assignment.
    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic [31:0]       result;
        logic [31:0]       rt_data;
        logic [4:0]        wa;
        logic [TNEW_W-1:0] tnew;
        logic              bd;
        logic [4:0]        exc;
        logic              load;
        logic              store;
        logic              valid;
    } em_regs_t;

    // Tnew counts down one per stage and parks at zero; it must never wrap
    // back to the maximum, or a finished producer would look busy again.
    function automatic logic [TNEW_W-1:0] age_tnew(input logic [TNEW_W-1:0] t);
        logic [TNEW_W-1:0] aged;
        if (t == '0) begin
            aged = '0;
        end else begin
            aged = t - TNEW_W'(1);
        end
        return aged;
    endfunction

    // An empty stage slot that still carries a PC (reset vector, handler
    // vector, or the macro-PC of a flushed instruction).
    function automatic em_regs_t empty_slot(input logic [31:0] pc);
        em_regs_t slot;
        slot    = '0;
        slot.pc = pc;
        return slot;
    endfunction

endpackage

// File: rtl/em_pipe_reg_exc_merge.sv
// Combinational ExcCode priority encoder for the E stage. An ExcCode already
// raised upstream wins; otherwise address-overflow on a load/store and then
// arithmetic overflow on a non-memory instruction are reported.
// Instantiated by em_pipe_reg only when EM_EXC_EN is defined.
module exc_merge
    import em_pipe_reg_pkg::*;
(
    input  logic [4:0] exc_i,
    input  logic       load_i,
    input  logic       store_i,
    input  logic       ov_i,
    input  logic       addr_ov_i,
    output logic [4:0] exc_o
);

    // First match wins: upstream code, AdEL, AdES, Ov, none.
    always_comb begin
        exc_o = EXC_NONE;
        if (exc_i != EXC_NONE) begin
            exc_o = exc_i;
        end else if (load_i && addr_ov_i) begin
            exc_o = EXC_ADEL;
        end else if (store_i && addr_ov_i) begin
            exc_o = EXC_ADES;
        end else if (ov_i && !load_i && !store_i) begin
            exc_o = EXC_OV;
        end
    end

endmodule

// File: rtl/em_pipe_reg.sv
// E/M pipeline register of the P7 MIPS core. Captures the E-stage result
// (ALU or HI/LO read-out), ages Tnew, merges E-stage exceptions, and handles
// reset, exception/interrupt clear (req) and bubble insertion (flush).
// Optional feature macro: EM_EXC_EN. When undefined, m_exc and m_bd stay 0,
// the exception inputs and e_bd are ignored, and m_wa is never suppressed.
module em_pipe_reg
    import em_pipe_reg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              flush,
    input  logic [31:0]       e_pc,
    input  logic [31:0]       e_instr,
    input  logic [31:0]       e_alu_out,
    input  logic [31:0]       e_hilo_out,
    input  logic              e_hilo_sel,
    input  logic [31:0]       e_rt_data,
    input  logic [4:0]        e_wa,
    input  logic [TNEW_W-1:0] e_tnew,
    input  logic              e_bd,
    input  logic [4:0]        e_exc,
    input  logic              e_ov,
    input  logic              e_addr_ov,
    input  logic              e_load,
    input  logic              e_store,
    output logic [31:0]       m_pc,
    output logic [31:0]       m_instr,
    output logic [31:0]       m_result,
    output logic [31:0]       m_rt_data,
    output logic [4:0]        m_wa,
    output logic [TNEW_W-1:0] m_tnew,
    output logic              m_bd,
    output logic [4:0]        m_exc,
    output logic              m_load,
    output logic              m_store,
    output logic              m_valid
);

    em_regs_t   regs_q;
    em_regs_t   regs_d;
    logic [4:0] merged_exc;
    logic       bd_in;

`ifdef EM_EXC_EN
    exc_merge u_exc_merge (
        .exc_i     (e_exc),
        .load_i    (e_load),
        .store_i   (e_store),
        .ov_i      (e_ov),
        .addr_ov_i (e_addr_ov),
        .exc_o     (merged_exc)
    );

    assign bd_in = e_bd;
`else
    logic unused_exc_inputs;

    assign merged_exc        = EXC_NONE;
    assign bd_in             = 1'b0;
    assign unused_exc_inputs = ^{e_exc, e_ov, e_addr_ov, e_bd};
`endif

    // Next-state selection: normal capture, then flush bubble, then req clear.
    always_comb begin
        regs_d         = '0;
        regs_d.pc      = e_pc;
        regs_d.instr   = e_instr;
        regs_d.result  = e_hilo_sel ? e_hilo_out : e_alu_out;
        regs_d.rt_data = e_rt_data;
        regs_d.tnew    = age_tnew(e_tnew);
        regs_d.bd      = bd_in;
        regs_d.exc     = merged_exc;
        regs_d.wa      = (merged_exc != EXC_NONE) ? 5'd0 : e_wa;
        regs_d.load    = e_load;
        regs_d.store   = e_store;
        regs_d.valid   = 1'b1;

        if (req) begin
            regs_d = empty_slot(HANDLER_PC);
        end else if (flush) begin
            regs_d    = empty_slot(e_pc);
            regs_d.bd = bd_in;
        end
    end

    // Stage register; synchronous reset loads the reset vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= empty_slot(RESET_PC);
        end else begin
            regs_q <= regs_d;
        end
    end

    assign m_pc      = regs_q.pc;
    assign m_instr   = regs_q.instr;
    assign m_result  = regs_q.result;
    assign m_rt_data = regs_q.rt_data;
    assign m_wa      = regs_q.wa;
    assign m_tnew    = regs_q.tnew;
    assign m_bd      = regs_q.bd;
    assign m_exc     = regs_q.exc;
    assign m_load    = regs_q.load;
    assign m_store   = regs_q.store;
    assign m_valid   = regs_q.valid;

endmodule

// File: tb/tb_em_pipe_reg.sv
// Self-checking bench for em_pipe_reg. Directed vectors push hand-computed
// expectations into a queue; a separate monitor pops one expectation after
// each clock edge that follows a driven vector and compares every output.
// Expected values follow EM_EXC_EN when the bench is built with it.
module tb_em_pipe_reg;

`ifdef EM_EXC_EN
    localparam bit EXC_ON = 1'b1;
`else
    localparam bit EXC_ON = 1'b0;
`endif

    typedef struct {
        logic        rst, req, flush;
        logic [31:0] pc, instr, alu, hilo, rt;
        logic        sel;
        logic [4:0]  wa;
        logic [1:0]  tnew;
        logic        bd;
        logic [4:0]  exc;
        logic        ov, addr_ov, load, store;
    } stim_t;

    typedef struct {
        string       tag;
        logic [31:0] pc, instr, result, rt;
        logic [4:0]  wa;
        logic [1:0]  tnew;
        logic        bd;
        logic [4:0]  exc;
        logic        load, store, valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] e_pc = '0, e_instr = '0, e_alu_out = '0, e_hilo_out = '0, e_rt_data = '0;
    logic        e_hilo_sel = 1'b0;
    logic [4:0]  e_wa = '0;
    logic [1:0]  e_tnew = '0;
    logic        e_bd = 1'b0;
    logic [4:0]  e_exc = '0;
    logic        e_ov = 1'b0, e_addr_ov = 1'b0, e_load = 1'b0, e_store = 1'b0;
    logic [31:0] m_pc, m_instr, m_result, m_rt_data;
    logic [4:0]  m_wa;
    logic [1:0]  m_tnew;
    logic        m_bd;
    logic [4:0]  m_exc;
    logic        m_load, m_store, m_valid;

    exp_t expQ[$];
    int   vecCount = 0;
    int   missCount = 0;

    em_pipe_reg dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .flush      (flush),
        .e_pc       (e_pc),
        .e_instr    (e_instr),
        .e_alu_out  (e_alu_out),
        .e_hilo_out (e_hilo_out),
        .e_hilo_sel (e_hilo_sel),
        .e_rt_data  (e_rt_data),
        .e_wa       (e_wa),
        .e_tnew     (e_tnew),
        .e_bd       (e_bd),
        .e_exc      (e_exc),
        .e_ov       (e_ov),
        .e_addr_ov  (e_addr_ov),
        .e_load     (e_load),
        .e_store    (e_store),
        .m_pc       (m_pc),
        .m_instr    (m_instr),
        .m_result   (m_result),
        .m_rt_data  (m_rt_data),
        .m_wa       (m_wa),
        .m_tnew     (m_tnew),
        .m_bd       (m_bd),
        .m_exc      (m_exc),
        .m_load     (m_load),
        .m_store    (m_store),
        .m_valid    (m_valid)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    function automatic stim_t idleStim(input logic [31:0] pc);
        stim_t s;
        s = '{default: '0};
        s.pc = pc;
        return s;
    endfunction

    function automatic exp_t emptyExp(input string tag, input logic [31:0] pc);
        exp_t e;
        e = '{tag: tag, default: '0};
        e.pc = pc;
        return e;
    endfunction

    task automatic checkField(input string tag, input string name,
                              input logic [31:0] act, input logic [31:0] req_v);
        vecCount++;
        if (act !== req_v) begin
            missCount++;
            $display("[TB] FAIL %s.%s: got 0x%08h, expected 0x%08h", tag, name, act, req_v);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField(e.tag, "m_pc",      m_pc,             e.pc);
        checkField(e.tag, "m_instr",   m_instr,          e.instr);
        checkField(e.tag, "m_result",  m_result,         e.result);
        checkField(e.tag, "m_rt_data", m_rt_data,        e.rt);
        checkField(e.tag, "m_wa",      32'(m_wa),        32'(e.wa));
        checkField(e.tag, "m_tnew",    32'(m_tnew),      32'(e.tnew));
        checkField(e.tag, "m_bd",      32'(m_bd),        32'(e.bd));
        checkField(e.tag, "m_exc",     32'(m_exc),       32'(e.exc));
        checkField(e.tag, "m_load",    32'(m_load),      32'(e.load));
        checkField(e.tag, "m_store",   32'(m_store),     32'(e.store));
        checkField(e.tag, "m_valid",   32'(m_valid),     32'(e.valid));
    endtask

    task automatic applyStimulus(input stim_t s, input exp_t e);
        @(negedge clk);
        rst        = s.rst;
        req        = s.req;
        flush      = s.flush;
        e_pc       = s.pc;
        e_instr    = s.instr;
        e_alu_out  = s.alu;
        e_hilo_out = s.hilo;
        e_hilo_sel = s.sel;
        e_rt_data  = s.rt;
        e_wa       = s.wa;
        e_tnew     = s.tnew;
        e_bd       = s.bd;
        e_exc      = s.exc;
        e_ov       = s.ov;
        e_addr_ov  = s.addr_ov;
        e_load     = s.load;
        e_store    = s.store;
        expQ.push_back(e);
    endtask

    // Monitor: one pending expectation is retired just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        stim_t s;
        exp_t  e;

        s = idleStim(32'h0000_3100); s.rst = 1'b1; s.wa = 5'd7; s.instr = 32'hFFFF_FFFF;
        applyStimulus(s, emptyExp("reset", 32'h0000_3000));

        s = idleStim(32'h0000_3010); s.instr = 32'h2402_0008; s.alu = 32'h55; s.hilo = 32'hAA;
        s.sel = 1'b1; s.rt = 32'h1111; s.wa = 5'd8; s.tnew = 2'd2;
        e = emptyExp("hilo_sel", 32'h0000_3010); e.instr = 32'h2402_0008; e.result = 32'hAA;
        e.rt = 32'h1111; e.wa = 5'd8; e.tnew = 2'd1; e.valid = 1'b1;
        applyStimulus(s, e);

        s = idleStim(32'h0000_3014); s.alu = 32'h55; s.hilo = 32'hAA; s.wa = 5'd8; s.tnew = 2'd0; s.bd = 1'b1;
        e = emptyExp("tnew0_alu", 32'h0000_3014); e.result = 32'h55; e.wa = 5'd8; e.tnew = 2'd0;
        e.bd = EXC_ON; e.valid = 1'b1;
        applyStimulus(s, e);

        s = idleStim(32'h0000_3018); s.alu = 32'hFFFF_FFFF; s.wa = 5'd2; s.tnew = 2'd3;
        e = emptyExp("tnew3", 32'h0000_3018); e.result = 32'hFFFF_FFFF; e.wa = 5'd2; e.tnew = 2'd2; e.valid = 1'b1;
        applyStimulus(s, e);

        s = idleStim(32'h0000_301C); s.exc = 5'd10; s.ov = 1'b1; s.wa = 5'd5; s.tnew = 2'd1;
        e = emptyExp("exc_keep", 32'h0000_301C); e.exc = EXC_ON ? 5'd10 : 5'd0;
        e.wa = EXC_ON ? 5'd0 : 5'd5; e.valid = 1'b1;
        applyStimulus(s, e);

        s = idleStim(32'h0000_3040); s.load = 1'b1; s.addr_ov = 1'b1; s.wa = 5'd3;
        e = emptyExp("adel", 32'h0000_3040); e.exc = EXC_ON ? 5'd4 : 5'd0;
        e.wa = EXC_ON ? 5'd0 : 5'd3; e.load = 1'b1; e.valid = 1'b1;
        applyStimulus(s, e);

        s = idleStim(32'h0000_3044); s.store = 1'b1; s.addr_ov = 1'b1; s.rt = 32'hCAFE;
        e = emptyExp("ades", 32'h0000_3044); e.exc = EXC_ON ? 5'd5 : 5'd0;
        e.rt = 32'hCAFE; e.store = 1'b1; e.valid = 1'b1;
        applyStimulus(s, e);

        s = idleStim(32'h0000_3048); s.ov = 1'b1; s.wa = 5'd9;
        e = emptyExp("ov_alone", 32'h0000_3048); e.exc = EXC_ON ? 5'd12 : 5'd0;
        e.wa = EXC_ON ? 5'd0 : 5'd9; e.valid = 1'b1;
        applyStimulus(s, e);

        s = idleStim(32'h0000_304C); s.ov = 1'b1; s.load = 1'b1; s.wa = 5'd7;
        e = emptyExp("load_ov", 32'h0000_304C); e.wa = 5'd7; e.load = 1'b1; e.valid = 1'b1;
        applyStimulus(s, e);

        s = idleStim(32'h0000_3020); s.flush = 1'b1; s.bd = 1'b1; s.instr = 32'h1234_5678;
        s.alu = 32'h77; s.wa = 5'd8; s.tnew = 2'd2; s.ov = 1'b1; s.load = 1'b1; s.rt = 32'h99;
        e = emptyExp("flush1", 32'h0000_3020); e.bd = EXC_ON;
        applyStimulus(s, e);

        s = idleStim(32'h0000_3024); s.flush = 1'b1; s.instr = 32'h0000_0001; s.wa = 5'd6; s.store = 1'b1;
        applyStimulus(s, emptyExp("flush2", 32'h0000_3024));

        s = idleStim(32'h0000_3028); s.req = 1'b1; s.flush = 1'b1; s.bd = 1'b1; s.instr = 32'hABCD_0000;
        s.alu = 32'h1; s.wa = 5'd4; s.tnew = 2'd2; s.load = 1'b1; s.rt = 32'h5;
        applyStimulus(s, emptyExp("req_flush", 32'h0000_4180));

        s = idleStim(32'h0000_302C); s.instr = 32'h0000_0010; s.hilo = 32'h1234; s.sel = 1'b1;
        s.wa = 5'd4; s.tnew = 2'd2;
        e = emptyExp("after_req", 32'h0000_302C); e.instr = 32'h0000_0010; e.result = 32'h1234;
        e.wa = 5'd4; e.tnew = 2'd1; e.valid = 1'b1;
        applyStimulus(s, e);

        s = idleStim(32'h0000_3030); s.rst = 1'b1; s.req = 1'b1; s.wa = 5'd1; s.instr = 32'h42;
        applyStimulus(s, emptyExp("rst_over_req", 32'h0000_3000));

        s = idleStim(32'h0000_3034); s.wa = 5'd31; s.tnew = 2'd1; s.alu = 32'h8000_0000; s.store = 1'b1;
        e = emptyExp("after_rst", 32'h0000_3034); e.result = 32'h8000_0000; e.wa = 5'd31;
        e.store = 1'b1; e.valid = 1'b1;
        applyStimulus(s, e);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
            @(negedge clk);
        end
        vecCount++;
        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL drain: got %0d pending, expected 0 pending", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
